// File: rtl/alu_zero_mask_gen.sv
// Rebuilds the 64-bit mask described by a clz/ctz zero count, one 8-bit slice per cycle.
// Each slice bit is produced by its own lane instance; the FSM walks the slices LSB first.
module alu_zero_mask_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0] idx,
  input  logic [6:0] ones_len,
  input  logic [6:0] cnt,
  input  logic       lead,
  output logic       bit_val
);
  logic [6:0] j;
  assign j       = {1'b0, idx, 3'(LANE)};
  assign bit_val = lead ? (j < ones_len) : (j >= cnt);
endmodule

module alu_zero_mask_gen #(
  parameter int XLEN    = 64,
  parameter int SLICE_W = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [6:0]      count_i,
  input  logic            leading_i,
  input  logic            word_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] mask_o,
  output logic            sat_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [6:0]  cnt_q;
  logic        lead_q, word_q, sat_q;

  logic [6:0]         w_in, w_q, ones_len;
  logic               sat_in;
  logic [6:0]         cnt_in;
  logic [SLICE_W-1:0] slice_bits;
  logic               last_slice;

  assign w_in     = word_i ? 7'd32 : 7'd64;
  assign sat_in   = count_i > w_in;
  assign cnt_in   = sat_in ? w_in : count_i;
  assign w_q      = word_q ? 7'd32 : 7'd64;
  // Leading form: the low (W-C) bits are ones; C never exceeds W so this cannot wrap.
  assign ones_len = w_q - cnt_q;

  for (genvar k = 0; k < SLICE_W; k++) begin : g_lane
    alu_zero_mask_lane #(.LANE(k)) u_lane (
      .idx      (idx),
      .ones_len (ones_len),
      .cnt      (cnt_q),
      .lead     (lead_q),
      .bit_val  (slice_bits[k])
    );
  end

  assign last_slice = word_q ? (idx == 3'd3) : (idx == 3'd7);

  always_ff @(posedge clk_i) begin
    if (!rstn_i || kill_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      mask_o  <= '0;
      sat_o   <= 1'b0;
      idx     <= '0;
      cnt_q   <= '0;
      lead_q  <= 1'b0;
      word_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          cnt_q   <= cnt_in;
          lead_q  <= leading_i;
          word_q  <= word_i;
          sat_q   <= sat_in;
          idx     <= '0;
          ready_o <= 1'b0;
          state   <= BUSY;
        end
        BUSY: begin
          mask_o[{idx, 3'b000} +: SLICE_W] <= slice_bits;
          idx <= idx + 3'd1;
          if (last_slice) begin
            // *W results sign-extend bit 31, which is the top bit of slice 3.
            if (word_q) mask_o[XLEN-1:32] <= {(XLEN-32){slice_bits[SLICE_W-1]}};
            sat_o   <= sat_q;
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_zero_mask_gen.sv
// Scoreboard bench for alu_zero_mask_gen: accepted requests push a reference result,
// a negedge monitor checks latency, mask and sat at each output handshake.
module tb_alu_zero_mask_gen;
  logic        clk_i = 1'b0;
  logic        rstn_i, valid_i, ready_o, leading_i, word_i, kill_i, valid_o, ready_i, sat_o;
  logic [6:0]  count_i;
  logic [63:0] mask_o;

  always #5 clk_i = ~clk_i;

  alu_zero_mask_gen dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .count_i(count_i), .leading_i(leading_i), .word_i(word_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .mask_o(mask_o), .sat_o(sat_o)
  );

  typedef struct {
    logic [63:0] mask;
    logic        sat;
    int          due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   rnd_rdy = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] low_ones(input int n);
    logic [127:0] t;
    t = (128'd1 << n) - 128'd1;
    return t[63:0];
  endfunction

  // Reference: mask straight from the W/C bit rules, no slicing.
  function automatic exp_t ref_model(input int cnt, input bit lead, input bit word);
    exp_t e;
    int w, c;
    w = word ? 32 : 64;
    c = (cnt > w) ? w : cnt;
    e.sat  = (cnt > w);
    e.mask = lead ? low_ones(w - c) : (low_ones(w) & ~low_ones(c));
    if (word) e.mask[63:32] = {32{e.mask[31]}};
    e.due = 0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_v;
    exp_t e;
    prev_v = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i || kill_i) begin
        q.delete();
      end else begin
        if (valid_o === 1'b1 && !prev_v) begin
          if (q.size() == 0) check64("unexpected_valid", 64'd1, 64'd0);
          else check64("latency", 64'(cyc), 64'(q[0].due));
        end
        if (valid_o === 1'b1 && ready_i) begin
          if (q.size() == 0) check64("extra_result", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            check64("mask", mask_o, e.mask);
            check64("sat", 64'(sat_o), 64'(e.sat));
          end
        end
        if (valid_i && ready_o === 1'b1) begin
          e = ref_model(int'(count_i), leading_i, word_i);
          e.due = cyc + 1 + (word_i ? 4 : 8);
          q.push_back(e);
        end
      end
      prev_v = (valid_o === 1'b1);
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rnd_rdy) ready_i = 1'($urandom % 2);
  end

  task automatic issue(input int cnt, input bit lead, input bit word);
    bit acc;
    int n;
    @(posedge clk_i); #1;
    valid_i = 1; count_i = 7'(cnt); leading_i = lead; word_i = word;
    acc = 0; n = 0;
    while (!acc && n < 60) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) acc = 1;
      n++;
    end
    if (!acc) check64("accept_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    valid_i = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || ready_o !== 1'b1) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check64("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    int n;
    bit seen;
    rstn_i = 0; valid_i = 0; count_i = 0; leading_i = 0; word_i = 0; kill_i = 0; ready_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check64("rst_ready", 64'(ready_o), 64'd1);
    check64("rst_valid", 64'(valid_o), 64'd0);
    check64("rst_mask", mask_o, 64'd0);
    check64("rst_sat", 64'(sat_o), 64'd0);
    @(posedge clk_i); #1;
    rstn_i = 1;

    // Directed cases
    issue(0, 0, 0);   wait_idle();
    issue(3, 0, 0);   wait_idle();
    issue(12, 1, 0);  wait_idle();
    issue(64, 1, 0);  wait_idle();
    issue(4, 1, 1);   wait_idle();
    issue(4, 0, 1);   wait_idle();
    issue(100, 0, 0); wait_idle();
    issue(40, 0, 1);  wait_idle();
    issue(127, 1, 1); wait_idle();
    issue(32, 1, 1);  wait_idle();

    // Back-pressure in DONE with a competing request
    ready_i = 0;
    issue(12, 1, 0);
    n = 0;
    while (valid_o !== 1'b1 && n < 30) begin @(negedge clk_i); n++; end
    if (n >= 30) check64("hold_valid_timeout", 64'd0, 64'd1);
    held = mask_o;
    check64("hold_mask_value", held, 64'h000F_FFFF_FFFF_FFFF);
    @(posedge clk_i); #1;
    valid_i = 1; count_i = 7'd5; leading_i = 0; word_i = 0;
    repeat (5) begin
      @(negedge clk_i);
      check64("hold_valid", 64'(valid_o), 64'd1);
      check64("hold_ready", 64'(ready_o), 64'd0);
      check64("hold_mask", mask_o, held);
    end
    @(posedge clk_i); #1;
    valid_i = 0; ready_i = 1;
    wait_idle();

    // Kill mid-BUSY, after slice 3 of a dword
    @(posedge clk_i); #1;
    valid_i = 1; count_i = 7'd5; leading_i = 0; word_i = 0;
    @(posedge clk_i); #1;
    valid_i = 0;
    repeat (3) @(posedge clk_i);
    #1 kill_i = 1;
    @(posedge clk_i); #1;
    kill_i = 0;
    @(negedge clk_i);
    check64("kill_ready", 64'(ready_o), 64'd1);
    check64("kill_valid", 64'(valid_o), 64'd0);
    check64("kill_mask", mask_o, 64'd0);
    seen = 0;
    repeat (12) begin @(negedge clk_i); if (valid_o !== 1'b0) seen = 1; end
    check64("kill_no_valid", 64'(seen), 64'd0);

    // Reset mid-BUSY, then a clean request
    @(posedge clk_i); #1;
    valid_i = 1; count_i = 7'd9; leading_i = 1; word_i = 0;
    @(posedge clk_i); #1;
    valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 0;
    @(posedge clk_i); #1;
    rstn_i = 1;
    @(negedge clk_i);
    check64("mrst_ready", 64'(ready_o), 64'd1);
    check64("mrst_valid", 64'(valid_o), 64'd0);
    check64("mrst_mask", mask_o, 64'd0);
    check64("mrst_sat", 64'(sat_o), 64'd0);
    issue(3, 0, 0); wait_idle();

    // Random traffic with random consumer back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      int c;
      c = ($urandom % 4 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 66));
      issue(c, 1'($urandom % 2), 1'($urandom % 2));
    end
    rnd_rdy = 0;
    @(posedge clk_i); #1;
    ready_i = 1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
